// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and iterative-unit mode select
// for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_INC_A = 4'b0000;
  localparam logic [3:0] OP_INC_B = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_SHR_A = 4'b0101;
  localparam logic [3:0] OP_SHL_A = 4'b0110;
  localparam logic [3:0] OP_SHR_B = 4'b0111;
  localparam logic [3:0] OP_SHL_B = 4'b1000;
  localparam logic [3:0] OP_MOD   = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b1010;
  localparam logic [3:0] OP_OR    = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unit: WIDTH-step shift-add multiply or restoring divide.
// Outputs are the post-step values, so they are final while done is high.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic             mode_q;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   sum, rs;

  // hi/lo hold accumulator/multiplier for multiply, remainder/dividend for divide
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    rs  = {hi, lo[WIDTH-1]};
    if (mode_q == MODE_MUL) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else if (rs >= {1'b0, m}) begin
      hi_n = WIDTH'(rs - {1'b0, m});
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = rs[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      mode_q <= MODE_MUL;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
    end else if (start) begin
      count  <= CW'(WIDTH);
      mode_q <= mode;
      hi     <= '0;
      lo     <= (mode == MODE_MUL) ? b : a;
      m      <= (mode == MODE_MUL) ? a : b;
    end else if (count != '0) begin
      count <= count - 1'b1;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  assign done      = (count == CW'(1));
  assign product   = {hi_n, lo_n};
  assign quotient  = lo_n;
  assign remainder = hi_n;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete at latency 1, multiply/divide/
// modulo run through alu_seq_iter; result held in DONE until handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             error
);

  state_t             state, state_n;
  logic [3:0]         op_q;
  logic               is_iter, div_zero, iter_start, iter_done, iter_mode;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;
  logic [WIDTH-1:0]   sc_result, it_result, result_q;
  logic               sc_ovf, sc_err, it_ovf, ovf_q, err_q;
  logic [WIDTH:0]     ext;

  assign is_iter  = (opcode == OP_MUL) || (opcode == OP_MOD) || (opcode == OP_DIV);
  assign div_zero = ((opcode == OP_MOD) || (opcode == OP_DIV)) && (op_b == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (is_iter && !div_zero) ? ITER : DONE;
      ITER:    if (iter_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    iter_start = (state == IDLE) && (state_n == ITER);
    iter_mode  = (opcode == OP_MUL) ? MODE_MUL : MODE_DIV;
  end

  // Single-cycle ops are evaluated on the request as it is captured
  always_comb begin
    ext       = '0;
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    case (opcode)
      OP_INC_A: begin ext = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_INC_B: begin ext = {1'b0, op_b} + {{WIDTH{1'b0}}, 1'b1}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_SUB:   begin ext = {1'b0, op_a} - {1'b0, op_b}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_ADD:   begin ext = {1'b0, op_a} + {1'b0, op_b}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_SHR_A: sc_result = op_a >> 1;
      OP_SHL_A: begin ext = {op_a, 1'b0}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_SHR_B: sc_result = op_b >> 1;
      OP_SHL_B: begin ext = {op_b, 1'b0}; sc_result = ext[WIDTH-1:0]; sc_ovf = ext[WIDTH]; end
      OP_AND:   sc_result = op_a & op_b;
      OP_OR:    sc_result = op_a | op_b;
      OP_XOR:   sc_result = op_a ^ op_b;
      OP_MUL:   sc_result = '0;
      OP_MOD,
      OP_DIV:   sc_err = div_zero;
      default:  sc_err = 1'b1;
    endcase
  end

  always_comb begin
    it_ovf = (op_q == OP_MUL) && (product[2*WIDTH-1:WIDTH] != '0);
    case (op_q)
      OP_MUL:  it_result = it_ovf ? '0 : product[WIDTH-1:0];
      OP_MOD:  it_result = remainder;
      default: it_result = quotient;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (in_valid && in_ready) op_q <= opcode;
      if (state == IDLE && state_n == DONE) begin
        result_q <= sc_result;
        ovf_q    <= sc_ovf;
        err_q    <= sc_err;
      end else if (state == ITER && state_n == DONE) begin
        result_q <= it_result;
        ovf_q    <= it_ovf;
        err_q    <= 1'b0;
      end else if (state == DONE && state_n == IDLE) begin
        result_q <= '0;
        ovf_q    <= 1'b0;
        err_q    <= 1'b0;
      end
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;
  assign error    = err_q;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (iter_start),
    .mode      (iter_mode),
    .a         (op_a),
    .b         (op_b),
    .done      (iter_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with an expectation queue.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, overflow, error;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0]   opcode;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] res, input logic ovf, input logic err, input int lat);
    exp_t e;
    e.res = res; e.ovf = ovf; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    int unsigned ia, ib, r;
    ia = a; ib = b; r = 0;
    e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      4'd0:  begin r = ia + 1;  e.ovf = (r > 255); end
      4'd1:  begin r = ib + 1;  e.ovf = (r > 255); end
      4'd2:  begin r = ia + 256 - ib; e.ovf = (ia < ib); end
      4'd3:  begin r = ia + ib; e.ovf = (r > 255); end
      4'd4:  begin r = ia * ib; e.lat = W + 1; e.ovf = (r > 255); if (r > 255) r = 0; end
      4'd5:  r = ia / 2;
      4'd6:  begin r = ia * 2; e.ovf = (r > 255); end
      4'd7:  r = ib / 2;
      4'd8:  begin r = ib * 2; e.ovf = (r > 255); end
      4'd9:  if (ib == 0) e.err = 1'b1; else begin r = ia % ib; e.lat = W + 1; end
      4'd10: r = ia & ib;
      4'd11: r = ia | ib;
      4'd12: r = ia ^ ib;
      4'd13: if (ib == 0) e.err = 1'b1; else begin r = ia / ib; e.lat = W + 1; end
      default: e.err = 1'b1;
    endcase
    e.res = r[W-1:0];
    return e;
  endfunction

  // Issue one request, keep junk on the inputs while busy, stall out_ready for hold cycles
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_before_req", in_ready, 1);
    op_a = a; op_b = b; opcode = op; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = W'($urandom); op_b = W'($urandom); opcode = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("out_valid", out_valid, 1);
    chk("latency", lat, e.lat);
    chk("result", result, e.res);
    chk("overflow", overflow, e.ovf);
    chk("error", error, e.err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, e.res);
      chk("hold_flags", {overflow, error}, {e.ovf, e.err});
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_result", result, 0);
  endtask

  initial begin
    exp_t e;
    int   seen;
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {overflow, error}, 2'b00);
    @(negedge clk); reset = 1'b0;

    push(8'd44, 1'b1, 1'b0, 1);      do_op(8'd200, 8'd100, 4'b0011, 0);
    push(8'd255, 1'b0, 1'b0, W + 1); do_op(8'd15, 8'd17, 4'b0100, 0);
    push(8'd0, 1'b1, 1'b0, W + 1);   do_op(8'd16, 8'd16, 4'b0100, 0);
    push(8'd28, 1'b0, 1'b0, W + 1);  do_op(8'd200, 8'd7, 4'b1101, 0);
    push(8'd4, 1'b0, 1'b0, W + 1);   do_op(8'd200, 8'd7, 4'b1001, 0);
    push(8'd0, 1'b0, 1'b1, 1);       do_op(8'd200, 8'd0, 4'b1101, 0);
    push(8'd0, 1'b0, 1'b1, 1);       do_op(8'd200, 8'd0, 4'b1001, 0);
    push(8'd0, 1'b0, 1'b1, 1);       do_op(8'd9, 8'd9, 4'b1111, 0);
    push(8'd0, 1'b0, 1'b1, 1);       do_op(8'd9, 8'd9, 4'b1110, 0);
    push(8'd254, 1'b1, 1'b0, 1);     do_op(8'd3, 8'd5, 4'b0010, 3);
    push(8'h54, 1'b1, 1'b0, 1);      do_op(8'hAA, 8'h01, 4'b0110, 0);
    push(8'd0, 1'b1, 1'b0, 1);       do_op(8'h00, 8'hFF, 4'b0001, 0);
    push(8'd255, 1'b0, 1'b0, W + 1); do_op(8'd255, 8'd1, 4'b1101, 2);

    for (int op = 0; op < 16; op++) begin
      ra = W'($urandom);
      rb = (op % 3 == 0) ? 8'd0 : W'($urandom);
      e = model(ra, rb, 4'(op));
      sb.push_back(e);
      do_op(ra, rb, 4'(op), op % 2);
    end

    // Abort a multiply mid-iteration; in_valid high alongside reset must be ignored
    @(negedge clk);
    op_a = 8'd100; op_b = 8'd3; opcode = 4'b0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out_valid", seen, 0);
    chk("abort_idle_in_ready", in_ready, 1);
    push(8'd0, 1'b1, 1'b0, 1);       do_op(8'd255, 8'd0, 4'b0000, 0);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  request present on op_a/op_b/opcode.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port op_a  input  WIDTH  operand A, unsigned.
REQ-007 The block SHALL have port op_b  input  WIDTH  operand B, unsigned.
REQ-008 The block SHALL have port opcode  input  4  operation select.
REQ-009 The block SHALL have port out_valid  output  1  result/flags valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-011 The block SHALL have port result  output  WIDTH  operation result.
REQ-012 The block SHALL have port overflow  output  1  unsigned overflow/borrow flag.
REQ-013 The block SHALL have port error  output  1  divide-by-zero or reserved opcode.

Function
REQ-014 The block SHALL implement states IDLE, ITER and DONE; in_ready = (state==IDLE).
REQ-015 A request SHALL be accepted when in_valid && in_ready; operands and opcode SHALL be captured into internal registers at that edge.
REQ-016 Opcodes 0000 A+1, 0001 B+1, 0010 A-B, 0011 A+B, 0101 A>>1, 0110 A<<1, 0111 B>>1, 1000 B<<1, 1010 A&B, 1011 A|B, 1100 A^B SHALL go IDLE->DONE with out_valid asserted on the cycle after acceptance (latency 1).
REQ-017 Opcodes 0100 A*B, 1001 A%B, 1101 A/B SHALL go IDLE->ITER, iterate exactly WIDTH cycles (shift-add multiply / restoring divide), then enter DONE (out_valid WIDTH+1 cycles after acceptance).
REQ-018 All arithmetic SHALL be unsigned and modulo 2^WIDTH.
REQ-019 Overflow SHALL be: increment -> operand all ones; A-B -> A<B; A+B -> carry out; A<<1/B<<1 -> shifted-out MSB; multiply -> upper WIDTH bits of the 2*WIDTH product nonzero, in which case result SHALL be 0; all other opcodes -> 0.
REQ-020 Opcodes 1001/1101 with B==0 SHALL skip ITER, go to DONE at latency 1 with result=0, error=1, overflow=0.
REQ-021 Opcodes 1110/1111 SHALL go to DONE at latency 1 with result=0, error=1, overflow=0.
REQ-022 In DONE, out_valid=1 and result/overflow/error SHALL stay stable until out_valid && out_ready, then the state SHALL return to IDLE on the next edge.
REQ-023 A new request SHALL NOT be accepted in the same cycle as the output handshake (in_ready is low in DONE); no back-to-back bypass.
REQ-024 in_valid, operand and opcode changes during ITER or DONE SHALL be ignored.
REQ-025 Outside DONE, out_valid SHALL be 0 and result/overflow/error SHALL be 0.

Reset
REQ-026 On reset the state SHALL become IDLE and out_valid, result, overflow, error and the iteration counter SHALL become 0; in_ready SHALL be 1 on the cycle after reset.
REQ-027 Reset asserted during ITER or DONE SHALL abort the operation, discard the pending result and produce no out_valid.
REQ-028 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-029 Opcode localparams and the state enum SHALL reside in shared package alu_seq_pkg.
REQ-030 The iterative multiply/divide datapath SHALL be sub-module alu_seq_iter (start, done, mode, a, b, product/quotient/remainder), with an iteration counter $clog2(WIDTH+1) bits wide.
REQ-031 Single-cycle ops SHALL be computed combinationally from the captured operands and registered into result in DONE entry.

Verification (WIDTH=8)
REQ-032 Opcode 0011, A=200, B=100 -> result=44, overflow=1, error=0, out_valid exactly 1 cycle after acceptance.
REQ-033 Opcode 0100, A=15, B=17 -> result=255, overflow=0 at 9 cycles after acceptance; A=16, B=16 -> result=0, overflow=1.
REQ-034 Opcode 1101, A=200, B=7 -> result=28; opcode 1001 same operands -> result=4; B=0 -> result=0, error=1, latency 1.
REQ-035 Opcode 1111 -> result=0, error=1; opcode 0010, A=3, B=5 -> result=254, overflow=1.
REQ-036 out_ready held low 3 cycles in DONE -> result/flags stable, in_ready=0; after handshake in_ready=1 next cycle, next request accepted.
REQ-037 Reset pulsed 4 cycles into a multiply -> no out_valid, in_ready=1 after reset; following A+1 with A=255 -> result=0, overflow=1.
